mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single main-memory port between the I-cache (read-only) and the D-cache (read/write).
//  Each grant carries one whole-block transaction. The block holds the winning request on the memory
//  bus until mem_ready, then returns data and a one-cycle ready pulse to the owner.
//  Sits between both caches and memory; o_mem_busy goes to the hazard/stall logic.
// PARAMETERS
//  ADDR_W     28   block address width (word address >> 2)
//  DATA_W     128  block width in bits (4 x 32-bit words)
//  STARVE_LIM 4    consecutive D grants, with I pending, before I is forced to win (1..15)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous active-high reset
//  ic_read      in   1       I-cache block read request; held until ic_ready
//  ic_addr      in   ADDR_W  I-cache block address
//  ic_rdata     out  DATA_W  read block returned to I-cache
//  ic_ready     out  1       one-cycle completion pulse to I-cache
//  dc_read      in   1       D-cache block read request; held until dc_ready
//  dc_write     in   1       D-cache block write-back request; held until dc_ready
//  dc_addr      in   ADDR_W  D-cache block address
//  dc_wdata     in   DATA_W  D-cache write-back block
//  dc_rdata     out  DATA_W  read block returned to D-cache
//  dc_ready     out  1       one-cycle completion pulse to D-cache
//  mem_read     out  1       memory read strobe; held until mem_ready
//  mem_write    out  1       memory write strobe; held until mem_ready
//  mem_addr     out  ADDR_W  memory block address
//  mem_wdata    out  DATA_W  memory write block
//  mem_rdata    in   DATA_W  memory read block; valid while mem_ready=1
//  mem_ready    in   1       memory completion, one cycle
//  o_mem_busy   out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset: every output is 0 and all internal registers clear: state=IDLE, owner=none, d_streak=0.
//  All outputs are registered.
//  States: IDLE -> GNT_I | GNT_D -> DONE -> IDLE.
//  IDLE: sample requests at the clock edge.
//   - d_req = dc_read | dc_write.
//   - Winner rule:
//     - D wins if d_req and not (ic_read and d_streak==STARVE_LIM).
//     - Otherwise I wins if ic_read.
//     - Otherwise stay in IDLE.
//   - On the winning edge: latch addr into mem_addr. For a D write, also latch dc_wdata into mem_wdata.
//     Then assert mem_read or mem_write and go to GNT_x.
//   - Latency: a request seen at edge N drives the memory strobe from cycle N+1.
//   - dc_read and dc_write both 1: treat as a write.
//   - d_streak update:
//     - ic_read pending on a D grant: saturating increment, stop at STARVE_LIM.
//     - I grant: d_streak=0.
//     - D grant with no ic_read pending: d_streak=0.
//  GNT_x: hold the strobe, mem_addr and mem_wdata stable. Ignore changes on the requester inputs.
//   - On mem_ready=1 at edge M:
//     - deassert the strobe;
//     - latch mem_rdata into x_rdata (reads only; writes leave x_rdata unchanged);
//     - set x_ready=1 for exactly the cycle M+1;
//     - go to DONE.
//  DONE: x_ready=1 for this cycle only. Next state is IDLE; x_ready returns to 0.
//   - The requester must drop its request at the edge ending DONE, so no stale re-grant is possible.
//   - Back-to-back grants are therefore separated by one IDLE cycle.
//  x_rdata holds its value until the next read completes for the same requester.
//  mem_ready in IDLE or DONE is ignored.
//  Only one of mem_read/mem_write is ever high; a ready pulse never goes to the non-owner.
//  Reset asserted mid-transaction: the transaction is abandoned, all outputs go to 0 at once, state=IDLE.
//  No retry after a transaction is abandoned by reset; the caches are also reset.
// TESTING
//  1 Lone I read: ic_read=1, ic_addr=0x0000010 -> mem_read=1 next cycle, mem_addr=0x0000010.
//    Then mem_ready with rdata=0x...A5 after 5 cycles -> ic_ready 1 cycle later, ic_rdata=0x...A5.
//  2 Simultaneous I read + D write (addr 0x20, wdata 0xDEAD..) -> D granted first (mem_write=1).
//    After dc_ready: one IDLE cycle, then mem_read for I.
//  3 Starvation, STARVE_LIM=4: ic_read held high while D requests back-to-back ->
//    exactly 4 D grants, then an I grant, then D again.
//  4 Stability: change dc_addr/dc_wdata mid-grant -> mem_addr/mem_wdata unchanged.
//    mem_ready in IDLE -> no ready pulse to either cache.
//  5 Reset mid-grant: assert rst while mem_read=1 -> all outputs 0 immediately.
//    After release with no requests: o_mem_busy=0, no ready pulse.
//  6 dc_read=dc_write=1 -> mem_write=1, mem_read=0; dc_rdata unchanged after dc_ready.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one block-wide memory port between the I-cache
// (reads only) and the D-cache (reads and write-backs). Each grant carries one
// whole-block transaction. A starvation counter stops the D-cache from locking
// out the I-cache indefinitely. Every output comes straight from a register.
module mem_port_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              o_mem_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Starvation limit fits in 4 bits (1..15).
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIM);

    state_t            state, stateNext;
    logic [3:0]        dStreak, dStreakNext;
    logic              memReadNext, memWriteNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memWdataNext;
    logic [DATA_W-1:0] icRdataNext, dcRdataNext;
    logic              icReadyNext, dcReadyNext;
    logic              busyNext;
    logic              dReq, dWins;

    // D-cache wins unless the I-cache is pending and has already waited through STARVE_LIM D grants.
    assign dReq  = dc_read | dc_write;
    assign dWins = dReq && !(ic_read && (dStreak == STREAK_MAX));

    // State and all registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dStreak    <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ic_rdata   <= '0;
            dc_rdata   <= '0;
            ic_ready   <= 1'b0;
            dc_ready   <= 1'b0;
            o_mem_busy <= 1'b0;
        end else begin
            state      <= stateNext;
            dStreak    <= dStreakNext;
            mem_read   <= memReadNext;
            mem_write  <= memWriteNext;
            mem_addr   <= memAddrNext;
            mem_wdata  <= memWdataNext;
            ic_rdata   <= icRdataNext;
            dc_rdata   <= dcRdataNext;
            ic_ready   <= icReadyNext;
            dc_ready   <= dcReadyNext;
            o_mem_busy <= busyNext;
        end
    end

    // Next-state and next-output logic; requester inputs matter only in IDLE, mem_ready only in GNT_x.
    always_comb begin
        stateNext    = state;
        dStreakNext  = dStreak;
        memReadNext  = mem_read;
        memWriteNext = mem_write;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        icRdataNext  = ic_rdata;
        dcRdataNext  = dc_rdata;
        icReadyNext  = 1'b0;
        dcReadyNext  = 1'b0;

        case (state)
            IDLE: begin
                if (dWins) begin
                    memAddrNext = dc_addr;
                    // A simultaneous read and write request is served as a write-back.
                    if (dc_write) begin
                        memWdataNext = dc_wdata;
                        memWriteNext = 1'b1;
                    end else begin
                        memReadNext = 1'b1;
                    end
                    if (ic_read) begin
                        if (dStreak != STREAK_MAX) dStreakNext = dStreak + 4'd1;
                    end else begin
                        dStreakNext = '0;
                    end
                    stateNext = GNT_D;
                end else if (ic_read) begin
                    memAddrNext = ic_addr;
                    memReadNext = 1'b1;
                    dStreakNext = '0;
                    stateNext   = GNT_I;
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    memReadNext = 1'b0;
                    icRdataNext = mem_rdata;
                    icReadyNext = 1'b1;
                    stateNext   = DONE;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    if (mem_read) dcRdataNext = mem_rdata;
                    memReadNext  = 1'b0;
                    memWriteNext = 1'b0;
                    dcReadyNext  = 1'b1;
                    stateNext    = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: lone I read, D-over-I priority,
// starvation limit, stability during a grant, combined read/write request
// and asynchronous reset in the middle of a grant.
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_read;
    logic [AW-1:0] ic_addr;
    logic [DW-1:0] ic_rdata;
    logic          ic_ready;
    logic          dc_read;
    logic          dc_write;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata;
    logic [DW-1:0] dc_rdata;
    logic          dc_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          o_mem_busy;

    int checks = 0;
    int passed = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ready(dc_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .o_mem_busy(o_mem_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction starting from IDLE: grant edge, optional wait, mem_ready, DONE.
    task automatic runGrant(input string tag, input bit expD, input bit expWr,
                            input logic [AW-1:0] expAddr, input logic [DW-1:0] expWdata,
                            input logic [DW-1:0] rd, input int waitCycles,
                            input logic [DW-1:0] expKeep);
        tick();
        check({tag, " mem_read"},  {127'd0, mem_read},  {127'd0, !expWr});
        check({tag, " mem_write"}, {127'd0, mem_write}, {127'd0, expWr});
        check({tag, " mem_addr"},  {100'd0, mem_addr},  {100'd0, expAddr});
        check({tag, " busy"},      {127'd0, o_mem_busy}, 128'd1);
        if (expWr) check({tag, " mem_wdata"}, mem_wdata, expWdata);
        for (int i = 0; i < waitCycles; i++) begin
            tick();
            check({tag, " hold strobe"}, {126'd0, mem_read, mem_write}, {126'd0, !expWr, expWr});
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        check({tag, " ready pair"}, {126'd0, ic_ready, dc_ready}, {126'd0, !expD, expD});
        check({tag, " strobes off"}, {126'd0, mem_read, mem_write}, 128'd0);
        if (expD) check({tag, " dc_rdata"}, dc_rdata, expWr ? expKeep : rd);
        else      check({tag, " ic_rdata"}, ic_rdata, rd);
        if (expD) begin
            dc_read  = 1'b0;
            dc_write = 1'b0;
        end else begin
            ic_read = 1'b0;
        end
        tick();
        check({tag, " ready drop"}, {126'd0, ic_ready, dc_ready}, 128'd0);
        check({tag, " idle busy"},  {127'd0, o_mem_busy}, 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        ic_read = 0; ic_addr = '0;
        dc_read = 0; dc_write = 0; dc_addr = '0; dc_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("reset outputs", {122'd0, ic_ready, dc_ready, mem_read, mem_write, o_mem_busy, 1'b0}, 128'd0);
        check("reset mem_addr", {100'd0, mem_addr}, 128'd0);
        check("reset ic_rdata", ic_rdata, 128'd0);
        check("reset dc_rdata", dc_rdata, 128'd0);

        // 1: lone I read
        ic_read = 1'b1;
        ic_addr = 28'h0000010;
        runGrant("t1", 1'b0, 1'b0, 28'h0000010, '0, 128'h1111_2222_3333_4444_5555_6666_7777_88A5, 4, '0);

        // 2: simultaneous I read and D write, D first; also stability mid-grant
        ic_read  = 1'b1;
        ic_addr  = 28'h0000030;
        dc_write = 1'b1;
        dc_addr  = 28'h0000020;
        dc_wdata = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        tick();
        check("t2 mem_write", {126'd0, mem_read, mem_write}, 128'd1);
        check("t2 mem_addr", {100'd0, mem_addr}, 128'h20);
        check("t2 mem_wdata", mem_wdata, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
        dc_addr  = 28'h00007FF;
        dc_wdata = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
        tick();
        check("t4 addr stable", {100'd0, mem_addr}, 128'h20);
        check("t4 wdata stable", mem_wdata, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
        check("t4 strobe held", {126'd0, mem_read, mem_write}, 128'd1);
        mem_ready = 1'b1;
        mem_rdata = 128'hFFFF;
        tick();
        mem_ready = 1'b0;
        check("t2 dc_ready", {126'd0, ic_ready, dc_ready}, 128'd1);
        check("t2 dc_rdata kept", dc_rdata, 128'd0);
        dc_write = 1'b0;
        tick();
        check("t2 idle gap", {125'd0, mem_read, mem_write, o_mem_busy}, 128'd0);
        runGrant("t2 I", 1'b0, 1'b0, 28'h0000030, '0, 128'hC0DE_0002, 1, '0);

        // 4: mem_ready while IDLE is ignored
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("t4 idle ready", {125'd0, ic_ready, dc_ready, o_mem_busy}, 128'd0);
        tick();
        check("t4 idle ready2", {125'd0, ic_ready, dc_ready, o_mem_busy}, 128'd0);

        // 3: starvation limit of 4
        ic_read = 1'b1;
        ic_addr = 28'h0000040;
        for (int k = 0; k < 4; k++) begin
            dc_read = 1'b1;
            dc_addr = 28'h0000100 + 28'(k);
            runGrant("t3 D", 1'b1, 1'b0, 28'h0000100 + 28'(k), '0, 128'hD000 + 128'(k), 0, '0);
        end
        dc_read = 1'b1;
        dc_addr = 28'h0000200;
        runGrant("t3 I forced", 1'b0, 1'b0, 28'h0000040, '0, 128'h1A1A_0040, 0, '0);
        runGrant("t3 D again", 1'b1, 1'b0, 28'h0000200, '0, 128'hD200, 0, '0);

        // 6: read and write together is a write; dc_rdata keeps last read
        dc_read  = 1'b1;
        dc_write = 1'b1;
        dc_addr  = 28'h0000066;
        dc_wdata = 128'h6666_0000_6666_0000_6666_0000_6666_0000;
        runGrant("t6", 1'b1, 1'b1, 28'h0000066, 128'h6666_0000_6666_0000_6666_0000_6666_0000,
                 128'hBADBAD, 2, 128'hD200);

        // 5: asynchronous reset during a read grant
        ic_read = 1'b1;
        ic_addr = 28'h0000055;
        tick();
        check("t5 granted", {127'd0, mem_read}, 128'd1);
        rst = 1'b1;
        #1;
        check("t5 strobes", {125'd0, mem_read, mem_write, o_mem_busy}, 128'd0);
        check("t5 mem_addr", {100'd0, mem_addr}, 128'd0);
        check("t5 ic_rdata", ic_rdata, 128'd0);
        check("t5 dc_rdata", dc_rdata, 128'd0);
        ic_read = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("t5 after release", {124'd0, ic_ready, dc_ready, mem_read, mem_write, o_mem_busy}, 128'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
